// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-wide, byte-addressed, big-endian data memory.
// Latency: ls_done in cycle 1 when misaligned, cycle 2 for LW/LH/LB/LHU/LBU/SW, cycle 3 for SB/SH (RMW).
// Backpressure: one request in flight; ls_ready is high only in IDLE and ls_req is ignored otherwise.
module load_store_unit #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ls_req,
    input  logic [2:0]        ls_op,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_ready,
    output logic              ls_done,
    output logic              ls_err,
    output logic [31:0]       ls_rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_cs,
    output logic              dm_wr,
    output logic              dm_rd,
    input  logic [31:0]       dm_dout
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_RMW_RD,
        S_RMW_WR,
        S_DONE
    } state_t;

    // Natural alignment: words on 4-byte, halfwords on 2-byte boundaries.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_LW, OP_SW:         mis = (off != 2'b00);
            OP_LH, OP_LHU, OP_SH: mis = off[0];
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Pick the big-endian lane out of the word and extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] off,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace the target byte/halfword lane of the fetched word with the store data.
    function automatic logic [31:0] merge_word(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] w, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (op == OP_SB) begin
            case (off)
                2'd0:    r[31:24] = d[7:0];
                2'd1:    r[23:16] = d[7:0];
                2'd2:    r[15:8]  = d[7:0];
                default: r[7:0]   = d[7:0];
            endcase
        end else if (op == OP_SH) begin
            if (off[1]) r[15:0]  = d[15:0];
            else        r[31:16] = d[15:0];
        end else begin
            r = d;
        end
        return r;
    endfunction

    state_t              state_q,   state_d;
    logic [2:0]          op_q,      op_d;
    logic [1:0]          off_q,     off_d;
    logic [31:0]         wdata_q,   wdata_d;
    logic [31:0]         merge_q,   merge_d;
    logic [31:0]         rdata_q,   rdata_d;
    logic                err_q,     err_d;
    logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
    logic                ready_q,   ready_d;
    logic                done_q,    done_d;
    logic                lserr_q,   lserr_d;

    logic                mem_cs;
    logic                mem_rd;
    logic                mem_wr;

    // Next-state, request latching, load extraction and merge-buffer capture.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        off_d     = off_q;
        wdata_d   = wdata_q;
        merge_d   = merge_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        dm_addr_d = dm_addr_q;
        case (state_q)
            S_IDLE: begin
                if (ls_req) begin
                    op_d      = ls_op;
                    off_d     = ls_addr[1:0];
                    wdata_d   = ls_wdata;
                    dm_addr_d = {ls_addr[ADDR_W-1:2], 2'b00};
                    err_d     = is_misaligned(ls_op, ls_addr[1:0]);
                    if (err_d)                state_d = S_DONE;
                    else if (ls_op <= OP_LHU) state_d = S_LOAD;
                    else if (ls_op == OP_SW)  state_d = S_WRITE;
                    else                      state_d = S_RMW_RD;
                end
            end
            S_LOAD: begin
                rdata_d = load_extend(op_q, off_q, dm_dout);
                state_d = S_DONE;
            end
            S_WRITE:  state_d = S_DONE;
            S_RMW_RD: begin
                merge_d = dm_dout;
                state_d = S_RMW_WR;
            end
            S_RMW_WR: state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
        lserr_d = (state_d == S_DONE) && err_d;
    end

    // State and registered handshake outputs; synchronous reset returns to IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= 3'b000;
            off_q     <= 2'b00;
            wdata_q   <= 32'h0;
            merge_q   <= 32'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
            dm_addr_q <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            lserr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            off_q     <= off_d;
            wdata_q   <= wdata_d;
            merge_q   <= merge_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            dm_addr_q <= dm_addr_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            lserr_q   <= lserr_d;
        end
    end

    // Memory strobes and write data decoded from the current state.
    always_comb begin
        mem_cs = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        dm_din = 32'h0;
        case (state_q)
            S_LOAD: begin
                mem_cs = 1'b1;
                mem_rd = 1'b1;
            end
            S_WRITE: begin
                mem_cs = 1'b1;
                mem_wr = 1'b1;
                dm_din = wdata_q;
            end
            S_RMW_RD: begin
                mem_cs = 1'b1;
                mem_rd = 1'b1;
            end
            S_RMW_WR: begin
                mem_cs = 1'b1;
                mem_wr = 1'b1;
                dm_din = merge_word(op_q, off_q, merge_q, wdata_q);
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset so a reset during a write cycle never commits it.
    assign dm_cs    = mem_cs & reset_n;
    assign dm_rd    = mem_rd & reset_n;
    assign dm_wr    = mem_wr & reset_n;
    assign dm_addr  = dm_addr_q;
    assign ls_ready = ready_q;
    assign ls_done  = done_q & reset_n;
    assign ls_err   = lserr_q & reset_n;
    assign ls_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ls_req;
    logic [2:0]    ls_op;
    logic [AW-1:0] ls_addr;
    logic [31:0]   ls_wdata;
    logic          ls_ready;
    logic          ls_done;
    logic          ls_err;
    logic [31:0]   ls_rdata;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_din;
    logic          dm_cs;
    logic          dm_wr;
    logic          dm_rd;
    wire  [31:0]   dm_dout;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ls_req   (ls_req),
        .ls_op    (ls_op),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_ready (ls_ready),
        .ls_done  (ls_done),
        .ls_err   (ls_err),
        .ls_rdata (ls_rdata),
        .dm_addr  (dm_addr),
        .dm_din   (dm_din),
        .dm_cs    (dm_cs),
        .dm_wr    (dm_wr),
        .dm_rd    (dm_rd),
        .dm_dout  (dm_dout)
    );

    // Byte memory seen by the DUT, and the model's copy of what it must hold
    logic [7:0] mem     [0:4095];
    logic [7:0] ref_mem [0:4095];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int cs_cnt = 0;
    int wr_cnt = 0;

    assign dm_dout = (dm_cs && dm_rd) ?
        {mem[{dm_addr[11:2], 2'd0}], mem[{dm_addr[11:2], 2'd1}],
         mem[{dm_addr[11:2], 2'd2}], mem[{dm_addr[11:2], 2'd3}]} : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dm_cs) cs_cnt <= cs_cnt + 1;
        if (dm_cs && dm_wr) wr_cnt <= wr_cnt + 1;
    end

    always @(posedge clk) begin
        if (dm_cs && dm_wr) begin
            mem[{dm_addr[11:2], 2'd0}] = dm_din[31:24];
            mem[{dm_addr[11:2], 2'd1}] = dm_din[23:16];
            mem[{dm_addr[11:2], 2'd2}] = dm_din[15:8];
            mem[{dm_addr[11:2], 2'd3}] = dm_din[7:0];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model of the operation in flight: timeline plus expected data
    bit          chk_en   = 1'b0;
    int          acc_cyc  = -10;
    int          done_cyc = -10;
    int          upd_cyc  = -10;
    logic        cur_mis, cur_load, cur_sw, cur_sub;
    logic [11:0] cur_wa;
    logic [31:0] cur_wword;
    logic [31:0] held_rd = 32'h0;
    logic [31:0] prev_rd = 32'h0;

    task automatic model_issue(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd);
        logic [11:0] wa;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        int          lat;
        wa       = {a[11:2], 2'b00};
        cur_load = (op <= 3'd4);
        cur_sw   = (op == 3'd7);
        cur_sub  = (op == 3'd5) || (op == 3'd6);
        cur_mis  = ((op == 3'd2 || op == 3'd7) && a[1:0] != 2'b00) ||
                   ((op == 3'd1 || op == 3'd4 || op == 3'd6) && a[0]);
        lat      = cur_mis ? 1 : (cur_sub ? 3 : 2);
        prev_rd  = held_rd;
        b = ref_mem[a];
        h = {ref_mem[a], ref_mem[a + 12'd1]};
        w = {ref_mem[wa], ref_mem[wa + 12'd1], ref_mem[wa + 12'd2], ref_mem[wa + 12'd3]};
        if (!cur_mis) begin
            case (op)
                3'd0: held_rd = {{24{b[7]}}, b};
                3'd1: held_rd = {{16{h[15]}}, h};
                3'd2: held_rd = w;
                3'd3: held_rd = {24'h0, b};
                3'd4: held_rd = {16'h0, h};
                3'd5: ref_mem[a] = wd[7:0];
                3'd6: begin
                    ref_mem[a]         = wd[15:8];
                    ref_mem[a + 12'd1] = wd[7:0];
                end
                default: begin
                    ref_mem[wa]         = wd[31:24];
                    ref_mem[wa + 12'd1] = wd[23:16];
                    ref_mem[wa + 12'd2] = wd[15:8];
                    ref_mem[wa + 12'd3] = wd[7:0];
                end
            endcase
            if (cur_load) upd_cyc = cyc + 2;
        end
        cur_wword = {ref_mem[wa], ref_mem[wa + 12'd1], ref_mem[wa + 12'd2], ref_mem[wa + 12'd3]};
        cur_wa    = wa;
        acc_cyc   = cyc;
        done_cyc  = cyc + lat;
    endtask

    // Per-cycle comparison of every DUT output against the model timeline
    always @(posedge clk) begin : cmp
        logic        in_op, e_done, e_rd, e_wr, e_cs;
        logic [31:0] e_rdata;
        #1;
        if (chk_en) begin
            in_op   = (cyc > acc_cyc) && (cyc <= done_cyc);
            e_done  = (cyc == done_cyc);
            e_rd    = in_op && !cur_mis && (cur_load || cur_sub) && (cyc == acc_cyc + 1);
            e_wr    = in_op && !cur_mis && ((cur_sw && cyc == acc_cyc + 1) ||
                                            (cur_sub && cyc == acc_cyc + 2));
            e_cs    = e_rd || e_wr;
            e_rdata = (cyc >= upd_cyc) ? held_rd : prev_rd;
            chk("ls_ready", ls_ready, !in_op);
            chk("ls_done",  ls_done,  e_done);
            chk("ls_err",   ls_err,   e_done && cur_mis);
            chk("ls_rdata", ls_rdata, e_rdata);
            chk("dm_cs",    dm_cs,    e_cs);
            chk("dm_rd",    dm_rd,    e_rd);
            chk("dm_wr",    dm_wr,    e_wr);
            if (e_cs) chk("dm_addr", dm_addr, cur_wa);
            if (e_wr) chk("dm_din_wr", dm_din, cur_wword);
            if (!e_cs) chk("dm_din_idle", dm_din, 32'h0);
        end
    end

    task automatic do_op(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wd,
                         input bit junk, output int lat, output logic err, output logic [31:0] rd);
        int g;
        lat = 0;
        err = 1'b0;
        rd  = 32'h0;
        g   = 0;
        @(negedge clk);
        while (!ls_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!ls_ready) begin
            chk("ready_timeout", ls_ready, 1);
            return;
        end
        ls_op    = op;
        ls_addr  = addr;
        ls_wdata = wd;
        ls_req   = 1'b1;
        model_issue(op, addr, wd);
        @(negedge clk);
        ls_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (ls_done) begin
                lat = k;
                err = ls_err;
                rd  = ls_rdata;
                break;
            end
            if (junk && !ls_ready && $urandom_range(0, 1) == 1) begin
                ls_req   = 1'b1;
                ls_op    = 3'($urandom_range(0, 7));
                ls_addr  = 12'($urandom);
                ls_wdata = $urandom;
            end else begin
                ls_req = 1'b0;
            end
            @(negedge clk);
        end
        ls_req = 1'b0;
        if (lat == 0) chk("done_timeout", ls_done, 1);
    endtask

    task automatic dir_op(input string nm, input logic [2:0] op, input logic [11:0] addr,
                          input logic [31:0] wd, input int exp_lat, input logic exp_err,
                          input bit chk_rd, input logic [31:0] exp_rd);
        int          lat;
        logic        err;
        logic [31:0] rd;
        do_op(op, addr, wd, 1'b0, lat, err, rd);
        chk({nm, "_lat"}, lat, exp_lat);
        chk({nm, "_err"}, err, exp_err);
        if (chk_rd) chk({nm, "_rdata"}, rd, exp_rd);
    endtask

    task automatic preload(input logic [11:0] wa, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            mem[wa + 12'(i)]     = w[31 - 8*i -: 8];
            ref_mem[wa + 12'(i)] = w[31 - 8*i -: 8];
        end
    endtask

    initial begin
        int c0;
        for (int i = 0; i < 4096; i++) begin
            logic [7:0] v;
            v          = 8'($urandom);
            mem[i]     = v;
            ref_mem[i] = v;
        end
        preload(12'h010, 32'h8899AABB);
        preload(12'h030, 32'h11223344);
        preload(12'hFFC, 32'h00000000);
        preload(12'h040, 32'hCAFEF00D);

        reset_n  = 1'b0;
        ls_req   = 1'b0;
        ls_op    = 3'd0;
        ls_addr  = '0;
        ls_wdata = 32'h0;
        #1;
        chk("rst_imm_done", ls_done, 0);
        chk("rst_imm_err",  ls_err,  0);
        chk("rst_imm_cs",   dm_cs,   0);
        chk("rst_imm_wr",   dm_wr,   0);
        chk("rst_imm_rd",   dm_rd,   0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",   ls_ready, 1);
        chk("rst_rdata",   ls_rdata, 32'h0);
        chk("rst_dm_addr", dm_addr,  12'h000);
        chk("rst_dm_din",  dm_din,   32'h0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        dir_op("lb_011",  3'd0, 12'h011, 32'h0, 2, 1'b0, 1'b1, 32'hFFFFFF99);
        dir_op("lbu_011", 3'd3, 12'h011, 32'h0, 2, 1'b0, 1'b1, 32'h00000099);
        dir_op("lh_012",  3'd1, 12'h012, 32'h0, 2, 1'b0, 1'b1, 32'hFFFFAABB);
        c0 = wr_cnt;
        dir_op("sw_020",  3'd7, 12'h020, 32'hDEADBEEF, 2, 1'b0, 1'b0, 32'h0);
        chk("sw_020_wr_cycles", wr_cnt - c0, 1);
        dir_op("lw_020",  3'd2, 12'h020, 32'h0, 2, 1'b0, 1'b1, 32'hDEADBEEF);
        dir_op("sb_032",  3'd5, 12'h032, 32'h000000AB, 3, 1'b0, 1'b0, 32'h0);
        dir_op("lw_030a", 3'd2, 12'h030, 32'h0, 2, 1'b0, 1'b1, 32'h1122AB44);
        dir_op("sh_030",  3'd6, 12'h030, 32'h00005566, 3, 1'b0, 1'b0, 32'h0);
        dir_op("lw_030b", 3'd2, 12'h030, 32'h0, 2, 1'b0, 1'b1, 32'h5566AB44);
        c0 = cs_cnt;
        dir_op("mis_lw_021",  3'd2, 12'h021, 32'h0, 1, 1'b1, 1'b1, 32'h5566AB44);
        dir_op("mis_sh_033",  3'd6, 12'h033, 32'h1234, 1, 1'b1, 1'b1, 32'h5566AB44);
        dir_op("mis_lhu_001", 3'd4, 12'h001, 32'h0, 1, 1'b1, 1'b1, 32'h5566AB44);
        chk("mis_no_cs", cs_cnt - c0, 0);
        dir_op("sb_fff",  3'd5, 12'hFFF, 32'h0000007E, 3, 1'b0, 1'b0, 32'h0);
        dir_op("lw_ffc",  3'd2, 12'hFFC, 32'h0, 2, 1'b0, 1'b1, 32'h0000007E);

        // Reset during the write half of an SB read-modify-write
        chk_en = 1'b0;
        @(negedge clk);
        chk("rmw_rst_start_ready", ls_ready, 1);
        ls_op    = 3'd5;
        ls_addr  = 12'h040;
        ls_wdata = 32'h0000005A;
        ls_req   = 1'b1;
        @(negedge clk);
        chk("rmw_rst_busy", ls_ready, 0);
        chk("rmw_rst_rd",   dm_rd,    1);
        ls_op    = 3'd7;
        ls_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        ls_req = 1'b0;
        chk("rmw_rst_wr",  dm_wr,  1);
        chk("rmw_rst_din", dm_din, 32'h5AFEF00D);
        reset_n = 1'b0;
        #1;
        chk("rmw_rst_wr_gated", dm_wr, 0);
        chk("rmw_rst_cs_gated", dm_cs, 0);
        @(posedge clk);
        #1;
        chk("rmw_rst_ready", ls_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        chk("rmw_rst_mem", {mem[12'h040], mem[12'h041], mem[12'h042], mem[12'h043]}, 32'hCAFEF00D);
        chk("rmw_rst_rdata", ls_rdata, 32'h0);
        held_rd  = 32'h0;
        prev_rd  = 32'h0;
        upd_cyc  = -10;
        acc_cyc  = -10;
        done_cyc = -10;
        chk_en   = 1'b1;

        for (int i = 0; i < 300; i++) begin
            logic [2:0]  op;
            logic [11:0] a;
            int          lat;
            logic        e;
            logic [31:0] r;
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 63)) : 12'($urandom);
            do_op(op, a, $urandom, 1'b1, lat, e, r);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        chk_en = 1'b0;
        for (int w = 0; w < 1024; w++) begin
            logic [11:0] wa;
            wa = 12'(w * 4);
            chk("mem_word",
                {mem[wa], mem[wa + 12'd1], mem[wa + 12'd2], mem[wa + 12'd3]},
                {ref_mem[wa], ref_mem[wa + 12'd1], ref_mem[wa + 12'd2], ref_mem[wa + 12'd3]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the datapath's MEM stage and the byte-addressable 4096x8 data memory. Accepts one load/store request at a time and checks natural alignment. Performs sub-word stores as a read-modify-write of the containing aligned word, because the memory always writes 4 bytes. Returns sign- or zero-extended load data with a one-cycle `done` pulse.

## Interface
- `ADDR_W`, 12: byte address width; memory span is 2^ADDR_W bytes.
- `clk`  in  1  rising-edge clock, shared with data memory.
- `reset_n`  in  1  synchronous, active-low reset.
- `ls_req`  in  1  request; sampled only when `ls_ready`=1.
- `ls_op`  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
- `ls_addr`  in  ADDR_W  byte address.
- `ls_wdata`  in  32  store data; SB uses [7:0], SH uses [15:0].
- `ls_ready`  out  1  high only in IDLE.
- `ls_done`  out  1  one-cycle completion pulse.
- `ls_err`  out  1  misaligned flag, valid with `ls_done`.
- `ls_rdata`  out  32  extended load result, held until next load completes.
- `dm_addr`  out  ADDR_W  memory address, always word-aligned ([1:0]=00).
- `dm_din`  out  32  memory write data.
- `dm_cs`, `dm_wr`, `dm_rd`  out  1 each  memory controls.
- `dm_dout`  in  32  memory read data; asynchronous, Z when not read.

## Operation
- Memory is big-endian. The byte at word offset 0 is bits [31:24]; offset 3 is [7:0]. A halfword at offset 0 is [31:16]; at offset 2 it is [15:0].
- Alignment rules:
  - LW/SW require `addr[1:0]`=00.
  - LH/LHU/SH require `addr[0]`=0.
  - Bytes are always aligned.
- Misaligned request: no memory access, `ls_err`=1, `ls_rdata` unchanged, memory untouched.
- Request accepted when `ls_req`=1 in IDLE. `ls_op`, `ls_addr` and `ls_wdata` are latched. `dm_addr` = {addr[ADDR_W-1:2],2'b00}.
- States:
  - IDLE -> DONE when the request is misaligned.
  - IDLE -> LOAD for any load.
  - IDLE -> WRITE for SW.
  - IDLE -> RMW_RD for SB/SH.
  - LOAD: cs=1, rd=1. Selected lane is extended and registered into `ls_rdata`. Next state DONE.
  - WRITE: cs=1, wr=1, `dm_din`=wdata. Next state DONE.
  - RMW_RD: cs=1, rd=1. `dm_dout` is registered into the merge buffer. Next state RMW_WR.
  - RMW_WR: cs=1, wr=1. `dm_din` is the merge buffer with the target lane replaced by wdata[7:0] or [15:0]. Next state DONE.
  - DONE: `ls_done`=1. Next state IDLE.
- Extension rules:
  - LB/LH sign-extend from bit 7/15 of the lane.
  - LBU/LHU zero-extend.
  - LW passes all 32 bits.
- Outside LOAD/WRITE/RMW states, `dm_cs`/`dm_wr`/`dm_rd` are 0 and `dm_din` is 0. `dm_dout` is never sampled then, so a Z bus is harmless.
- `dm_wr` and `dm_rd` are never both 1.

## Timing
- Cycle numbering: the request is sampled at the edge ending cycle 0.
- Latency to `ls_done`:
  - Misaligned: cycle 1.
  - LW/LH/LB/LHU/LBU/SW: cycle 2.
  - SB/SH: cycle 3.
- `ls_ready` returns the cycle after DONE. Back-to-back throughput is one op per 3 cycles (4 for SB/SH).
- `ls_rdata` updates at the edge ending LOAD and is stable while `ls_done`=1.
- The memory write commits at the edge ending WRITE or RMW_WR. A load issued after `ls_done` observes the new data.
- `ls_req` while `ls_ready`=0 is ignored; the requester holds the request until accepted.
- Reset values: state IDLE, `ls_ready`=1 after the reset edge.
  - 0 immediately: `ls_done`, `ls_err`, `dm_cs`, `dm_wr`, `dm_rd`.
  - 0 after the reset edge: `ls_rdata`, `dm_addr`, `dm_din`.
  - `dm_cs`/`dm_wr`/`dm_rd` are gated by `reset_n` combinationally.
- Reset mid-operation:
  - Asserted during RMW_WR or WRITE: the write is suppressed and memory is unchanged.
  - Asserted during RMW_RD: the operation is aborted and no write follows.
- Top word: address 4092-4095 is legal; the word address never exceeds 4092, so there is no address wrap.

## Test plan
- Preload word 0x010 = 0x8899AABB.
  - LB 0x011 -> `ls_rdata`=0xFFFFFF99, done in cycle 2.
  - LBU 0x011 -> 0x00000099.
  - LH 0x012 -> 0xFFFFAABB.
- SW 0x020 data 0xDEADBEEF, then LW 0x020 -> 0xDEADBEEF. `dm_wr` is high exactly one cycle.
- Preload 0x030 = 0x11223344.
  - SB 0x032 data 0x000000AB: RMW_RD then RMW_WR, done in cycle 3; LW 0x030 -> 0x1122AB44.
  - SH 0x030 data 0x5566: LW -> 0x5566AB44.
- LW 0x021, SH 0x033, LHU 0x001 -> `ls_err`=1 in cycle 1, `dm_cs` never asserted, memory and `ls_rdata` unchanged.
- SB 0xFFF data 0x7E on preloaded 0xFFC = 0x00000000 -> LW 0xFFC = 0x0000007E, `dm_addr`=0xFFC.
- `reset_n`=0 during RMW_WR of SB 0x040 -> word 0x040 unchanged, `ls_ready`=1 after the edge. A `ls_req` pulse while busy is ignored.
